restoring_divider: RTL and testbench
====================================

Name: restoring_divider

Overview:
Sequential unsigned restoring divider. It is the inverse-operation companion to the Booth multiplier datapath: one quotient bit per clock, with A/Q/M registers, an iteration counter and a small controller in one block. It accepts a dividend/divisor pair on a start pulse and returns quotient and remainder with a one-cycle done pulse. It sits beside the multiplier in the arithmetic unit and uses the same operand width.

Parameters:
WIDTH, 5, operand width in bits for dividend, divisor, quotient and remainder.

Ports:
clk  input  1  rising-edge clock, the only clock.
rst  input  1  synchronous active-high reset.
start  input  1  request. Sampled only in IDLE or DONE.
dividend  input  WIDTH  unsigned dividend, captured on an accepted start.
divisor  input  WIDTH  unsigned divisor, captured on an accepted start.
quotient  output  WIDTH  result quotient. Valid from done onward; held until the next accepted start.
remainder  output  WIDTH  result remainder. Same validity as quotient.
busy  output  1  high while iterating (CALC state).
done  output  1  one-cycle pulse when results become valid.
div_by_zero  output  1  set with done when divisor==0. Held with the results.

Behaviour:
- Reset: applied on any clk edge with rst=1, including mid-operation.
  - state<=IDLE.
  - A, Q, M, count, quotient, remainder <= 0.
  - busy=0, done=0, div_by_zero=0.
  - An in-flight division is discarded.
- Registers:
  - A: WIDTH+1 bits (the extra bit is the sign/borrow bit).
  - Q, M: WIDTH bits each.
  - count: $clog2(WIDTH+1) bits.
- States: IDLE, CALC, DONE. State is encoded via a package enum.
- IDLE or DONE with start=1:
  - divisor!=0: A<=0, Q<=dividend, M<=divisor, count<=WIDTH, div_by_zero<=0, go to CALC.
  - divisor==0: quotient<={WIDTH{1'b1}}, remainder<=dividend, div_by_zero<=1, go to DONE. done is high on the next cycle.
- CALC, each edge performs one step:
  - {A,Q} are shifted left 1 as a concatenated value.
  - T = A_shifted - {1'b0,M}, computed at WIDTH+1 bits.
  - If T[WIDTH]==1 (negative): restore, so A keeps A_shifted and Q[0]<=0.
  - Otherwise: A<=T and Q[0]<=1.
  - count<=count-1.
  - On the edge where count==1, the final step runs. At that same edge: quotient<=final Q, remainder<=final A[WIDTH-1:0], state<=DONE.
- DONE:
  - done=1 for exactly this one cycle. Next state is IDLE unless start=1; a start here is accepted as in IDLE (back-to-back operation).
  - quotient, remainder and div_by_zero hold their values through IDLE.
- Latency: with start sampled at edge k, iterations occur at edges k+1..k+WIDTH, and done is high in the cycle following edge k+WIDTH. Total is WIDTH+1 cycles from start to done; divide-by-zero takes 1 cycle.
- busy=1 exactly during the WIDTH CALC cycles. start while busy is ignored (no queueing) and inputs are not re-captured.
- Input changes on dividend/divisor after capture have no effect.
- Invariants: dividend == quotient*divisor + remainder, and remainder < divisor, whenever divisor!=0.
- done and busy are never high together.

Decomposition:
- Shared package div_pkg holds:
  - typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t.
  - localparam DIV_WIDTH_DEFAULT = 5.
- One sub-module: div_step. It is combinational, performing a single shift-subtract-restore iteration.
  - Inputs: A (WIDTH+1), Q (WIDTH), M (WIDTH).
  - Outputs: next A, next Q.
  - The top instantiates it once. The FSM, counter and result registers stay in restoring_divider.

Test Plan:
1. WIDTH=5: start with dividend=27, divisor=5 -> busy high for 5 cycles. done pulses 6 cycles after start with quotient=5, remainder=2, div_by_zero=0.
2. dividend=31, divisor=1 -> quotient=31, remainder=0. Also dividend=3, divisor=7 -> quotient=0, remainder=3.
3. dividend=13, divisor=0 -> done one cycle after start, quotient=31, remainder=13, div_by_zero=1, busy never high.
4. Start 20/3; re-assert start with 9/9 during the 3rd CALC cycle -> ignored, result quotient=6, remainder=2. Then a start in the DONE cycle with 9/9 is accepted -> next done gives quotient=1, remainder=0.
5. Start 30/4, assert rst during the 2nd CALC cycle -> next cycle shows IDLE and all outputs 0, with no done pulse. A fresh 30/4 then gives quotient=7, remainder=2.
6. Random sweep of all 32x32 operand pairs -> results match the reference integer division, and remainder=dividend with quotient=31 for divisor=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider.
//   div_state_t        : controller state encoding (IDLE, CALC, DONE)
//   DIV_WIDTH_DEFAULT  : default operand width, shared with the multiplier
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 5;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational.
// Ports:
//   a_i [WIDTH:0]   partial remainder A (top bit is the borrow bit)
//   q_i [WIDTH-1:0] dividend/quotient shift register Q
//   m_i [WIDTH-1:0] divisor M
//   a_o [WIDTH:0]   A after shift, trial subtract and optional restore
//   q_o [WIDTH-1:0] Q after shift with the new quotient bit in bit 0
module div_step #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH:0]   a_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0]   a_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH:0]   t;

  // A stays below M between steps, so its borrow bit is always 0 here and
  // shifting {A,Q} left only needs A's low WIDTH bits plus Q's MSB.
  assign a_sh = {a_i[WIDTH-1:0], q_i[WIDTH-1]};
  assign q_sh = q_i << 1;
  // a_sh < 2*M, so a negative difference always lands with bit WIDTH set.
  assign t    = a_sh - {1'b0, m_i};

  always_comb begin
    a_o = a_sh;
    q_o = q_sh;
    if (t[WIDTH]) begin
      a_o = a_sh;               // restore
      q_o = {q_sh[WIDTH-1:1], 1'b0};
    end else begin
      a_o = t;
      q_o = {q_sh[WIDTH-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Handshake: a start pulse is accepted only in IDLE or DONE; operands are
// captured on that edge. done is a one-cycle pulse in the DONE state, and
// quotient/remainder/div_by_zero are valid from done until the next
// accepted start. busy is high exactly during the WIDTH CALC cycles; a
// start while busy is ignored.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   start                request
//   dividend, divisor    operands
//   quotient, remainder  results
//   busy, done           status
//   div_by_zero          divisor was zero (quotient all ones, remainder=dividend)
//   dbg_state            current controller state
module restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output div_state_t       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t       state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] q_next;

  div_step #(.WIDTH(WIDTH)) u_step (
    .a_i (a_q),
    .q_i (q_q),
    .m_i (m_q),
    .a_o (a_next),
    .q_o (q_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      count_q <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      count_q <= count_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    count_d = count_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (divisor != '0) begin
            a_d     = '0;
            q_d     = dividend;
            m_d     = divisor;
            count_d = CW'(WIDTH);
            dbz_d   = 1'b0;
            state_d = CALC;
          end else begin
            // Divide by zero finishes immediately with a fixed result.
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        a_d     = a_next;
        q_d     = q_next;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          // Last iteration: publish the step outputs directly.
          quot_d  = q_next;
          rem_d   = a_next[WIDTH-1:0];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider (WIDTH=5): directed scenarios
// plus a shuffled sweep of every operand pair, with a scoreboard queue of
// expected {div_by_zero, quotient, remainder} consumed by a done monitor.
module tb_restoring_divider;
  import div_pkg::*;

  localparam int W = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient, remainder;
  logic         busy, done, div_by_zero;
  div_state_t   dbg_state;

  restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [2*W:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: plain integer division.
  function automatic logic [2*W:0] model(input int a, input int b);
    if (b == 0) return {1'b1, {W{1'b1}}, W'(a)};
    return {1'b0, W'(a / b), W'(a % b)};
  endfunction

  // Monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (done && busy) check("done_and_busy", 1, 0);
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", {21'd0, div_by_zero, quotient, remainder}, 32'hffff_ffff);
      end else begin
        logic [2*W:0] e;
        e = exp_q.pop_front();
        check("result", {21'd0, div_by_zero, quotient, remainder}, {21'd0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Drives a request at the current (negedge) point; the next posedge samples it.
  task automatic issue(input int a, input int b, input bit push);
    start    = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    if (push) exp_q.push_back(model(a, b));
  endtask

  // Waits for done, counting cycles from the start edge and busy cycles.
  task automatic wait_done(output int lat, output int bc, input bit scramble);
    lat = 0;
    bc  = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) start = 1'b0;
      if (busy) bc++;
      if (scramble) begin
        dividend = W'($urandom_range(0, 31));
        divisor  = W'($urandom_range(0, 31));
      end
    end while (!done && lat < 30);
    if (!done) check("done_timeout", 0, 1);
  endtask

  int lat, bc, dcnt;
  int order[1024];

  initial begin
    // reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_outputs", {27'd0, busy, done, div_by_zero, quotient != 0, remainder != 0}, 0);

    // 27 / 5
    issue(27, 5, 1);
    wait_done(lat, bc, 0);
    check("lat_27_5", lat, W + 1);
    check("busy_27_5", bc, W);

    // 31 / 1 and 3 / 7
    @(negedge clk); issue(31, 1, 1); wait_done(lat, bc, 0);
    check("lat_31_1", lat, W + 1);
    @(negedge clk); issue(3, 7, 1); wait_done(lat, bc, 0);
    check("lat_3_7", lat, W + 1);

    // 13 / 0
    @(negedge clk); issue(13, 0, 1); wait_done(lat, bc, 0);
    check("lat_div0", lat, 1);
    check("busy_div0", bc, 0);

    // 20 / 3 with an ignored start in the 3rd CALC cycle, then a start in DONE.
    @(negedge clk);
    issue(20, 3, 1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) start = 1'b0;
      if (lat == 3) begin start = 1'b1; dividend = 5'd9; divisor = 5'd9; end
      if (lat == 4) start = 1'b0;
    end while (!done && lat < 30);
    check("lat_20_3", lat, W + 1);
    issue(9, 9, 1);
    wait_done(lat, bc, 0);
    check("lat_b2b_9_9", lat, W + 1);

    // 30 / 4 aborted by reset in the 2nd CALC cycle.
    @(negedge clk);
    issue(30, 4, 0);
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    check("abort_outputs", {27'd0, busy, done, div_by_zero, quotient != 0, remainder != 0}, 0);
    dcnt = 0;
    repeat (8) begin @(negedge clk); if (done) dcnt++; end
    check("abort_no_done", dcnt, 0);
    issue(30, 4, 1);
    wait_done(lat, bc, 0);
    check("lat_30_4", lat, W + 1);

    // Shuffled sweep of every operand pair, with operand scrambling during
    // the operation and random gaps (gap 0 restarts from DONE).
    for (int i = 0; i < 1024; i++) order[i] = i;
    for (int i = 1023; i > 0; i--) begin
      int j, tmp;
      j = $urandom_range(0, i);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    @(negedge clk);
    for (int i = 0; i < 1024; i++) begin
      int a, b;
      a = order[i] / 32;
      b = order[i] % 32;
      issue(a, b, 1);
      wait_done(lat, bc, 1);
      check("lat_sweep", lat, (b == 0) ? 1 : W + 1);
      check("busy_sweep", bc, (b == 0) ? 0 : W);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
